fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 The block SHALL have parameter FB_W, default 160, meaning framebuffer width in pixels.
REQ-002 The block SHALL have parameter FB_H, default 120, meaning framebuffer height in pixels.
REQ-003 The block SHALL have parameter QDEPTH, default 4, meaning CPU write-queue depth (power of 2).
REQ-004 clk_pix  in  1  pixel clock; sole clock of the block.
REQ-005 rst_pix  in  1  reset, asynchronous, active-high.
REQ-006 sx, sy  in  10 each  current screen coordinates from the 480p timing generator.
REQ-007 de  in  1  active-video flag.
REQ-008 cpu_wr_valid, cpu_wr_ready  in/out  1 each  CPU pixel-write handshake; transfer on valid && ready.
REQ-009 cpu_wr_addr, cpu_wr_data  in  15 / 3  linear framebuffer address; RGB bits.
REQ-010 clr_req, clr_color  in  1 / 3  single-cycle clear-screen request; fill colour.
REQ-011 clr_busy  out  1  clear in progress.
REQ-012 mem_en, mem_we, mem_addr, mem_wdata  out  1 / 1 / 15 / 3  single-port framebuffer RAM port.
REQ-013 mem_rdata  in  3  RAM read data, valid one cycle after mem_en && !mem_we.
REQ-014 rgb  out  3  fetched pixel for the VGA output stage.
REQ-015 q_level, addr_err  out  3 / 1  queue occupancy; sticky out-of-range-write flag.

Function
REQ-016 Exactly one RAM access (display read, clear write, or queue write) SHALL be issued per cycle at most, with priority display read > clear write > queue write.
REQ-017 A display read SHALL be issued when de && sx[1:0]==0, at address (sy>>2)*FB_W + (sx>>2), computed as shifts and adds (y<<7)+(y<<5), no multiplier.
REQ-018 rgb SHALL update on the cycle after mem_rdata is valid (2 cycles after the read slot) and hold until the next display read returns.
REQ-019 All mem_* outputs SHALL be registered; mem_en SHALL be 0 on cycles with no access.
REQ-020 cpu_wr_ready SHALL equal !full, registered; an accepted write with cpu_wr_addr >= FB_W*FB_H SHALL be dropped, not enqueued, and SHALL set addr_err until reset.
REQ-021 When the queue is full, no enqueue SHALL occur, even if a dequeue happens in the same cycle; simultaneous enqueue and dequeue when not full SHALL leave q_level unchanged.
REQ-022 The control FSM SHALL have states IDLE and CLEAR; clr_req in IDLE -> CLEAR, clear counter=0, clr_busy=1.
REQ-023 In CLEAR, each cycle not taken by a display read SHALL write clr_color at the counter address and increment the counter; after address FB_W*FB_H-1 is written -> IDLE, clr_busy=0 the next cycle.
REQ-024 clr_req while in CLEAR SHALL be ignored; the queue SHALL NOT drain during CLEAR but SHALL keep accepting writes until full.
REQ-025 In IDLE, a non-empty queue SHALL dequeue one entry per free slot, in FIFO order.

Reset
REQ-026 On rst_pix asserted: FSM=IDLE, queue empty, q_level=0, cpu_wr_ready=0 then 1 on the first clock after release, clr_busy=0, addr_err=0, rgb=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0.
REQ-027 Reset mid-clear SHALL abort the clear, and queued writes SHALL be discarded.

Structure
REQ-028 The package fb_pkg SHALL hold FB_W, FB_H, FB_DEPTH, ADDR_W=15, PIX_W=3, QDEPTH, and the FSM state enum.
REQ-029 The write queue SHALL be a sub-module fb_wr_fifo (sync FIFO, async reset, full/empty/level).

Verification
REQ-030 Active line sy=8, sx=0..15: reads at addresses 320,321,322,323 on sx=0,4,8,12; RAM returns 5 -> rgb=5 from sx=2.
REQ-031 Four back-to-back CPU writes during de with no gaps: cpu_wr_ready drops after the 4th; all four entries appear on mem_* in order, only on non-read cycles.
REQ-032 CPU write to address 19200: no RAM write occurs, addr_err=1 and stays 1, and q_level is unchanged.
REQ-033 clr_req with clr_color=3'b010 during blanking: 19200 consecutive writes 0..19199, clr_busy falls after the last write, and a second clr_req mid-clear has no effect.
REQ-034 rst_pix asserted at clear count 100 with 2 queued writes: all outputs reach their reset values, and no further mem_en occurs until new stimulus.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared sizes and types for the
// framebuffer arbiter slice.
package fb_pkg;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 15;
  localparam int PIX_W    = 3;
  localparam int QDEPTH   = 4;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = S_IDLE,
    CLEAR = S_CLEAR
  } fb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } fb_wr_t;
endpackage

// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: CPU write handshake and
// single-port framebuffer RAM bus.
interface fb_arbiter_if;
  import fb_pkg::*;

  logic              cpu_wr_valid;
  logic              cpu_wr_ready;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [PIX_W-1:0]  cpu_wr_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport slave (
    input  cpu_wr_valid,
    input  cpu_wr_addr,
    input  cpu_wr_data,
    input  mem_rdata,
    output cpu_wr_ready,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output cpu_wr_valid,
    output cpu_wr_addr,
    output cpu_wr_data,
    output mem_rdata,
    input  cpu_wr_ready,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: small sync FIFO holding
// pending CPU pixel writes.
module fb_wr_fifo import fb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  fb_wr_t                 din_i,
  output fb_wr_t                 dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  fb_wr_t         mem_q [DEPTH];
  logic [AW-1:0]  wp_q, rp_q;
  logic [LW-1:0]  cnt_q;
  logic           do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one framebuffer RAM port
// between display fetch, clear and CPU writes.
module fb_arbiter import fb_pkg::*; #(
  parameter int FB_W   = fb_pkg::FB_W,
  parameter int FB_H   = fb_pkg::FB_H,
  parameter int QDEPTH = fb_pkg::QDEPTH
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic [9:0]              sx,
  input  logic [9:0]              sy,
  input  logic                    de,
  input  logic                    clr_req,
  input  logic [PIX_W-1:0]        clr_color,
  output logic                    clr_busy,
  output logic [PIX_W-1:0]        rgb,
  output logic [$clog2(QDEPTH):0] q_level,
  output logic                    addr_err,
  fb_arbiter_if.slave             bus
);
  localparam int LW = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-1:0] LIMIT =
    ADDR_W'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FB_W * FB_H - 1);

  fb_state_e         st_q, st_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0]  col_q, col_d;
  logic              last_q, last_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  wd_q, wd_d;
  logic              disp_q, disp_d;
  logic              rdv_q;
  logic [PIX_W-1:0]  rgb_q, rgb_d;

  logic              slot, ok, enq, deq;
  logic              full, empty;
  fb_wr_t            din, head;
  logic [LW-1:0]     lvl, lvl_n;
  logic [ADDR_W-1:0] yw, rd_addr;
  logic              unused_lsb;

  assign unused_lsb = ^sy[1:0];

  fb_wr_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk     (clk_pix),
    .rst     (rst_pix),
    .push_i  (enq),
    .pop_i   (deq),
    .din_i   (din),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (lvl)
  );

  // fetch address (y*160 + x) and CPU write acceptance
  always_comb begin
    yw      = ADDR_W'(sy[9:2]);
    rd_addr = (yw << 7) + (yw << 5)
            + ADDR_W'(sx[9:2]);
    slot    = de && (sx[1:0] == 2'b00);
    ok      = bus.cpu_wr_addr < LIMIT;
    din     = '{addr: bus.cpu_wr_addr,
                data: bus.cpu_wr_data};
    enq     = bus.cpu_wr_valid && rdy_q
            && ok && !full;
    err_d   = err_q || (bus.cpu_wr_valid
            && rdy_q && !ok);
  end

  // port priority: fetch > clear > queue drain
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    col_d  = col_q;
    last_d = 1'b0;
    en_d   = 1'b0;
    we_d   = 1'b0;
    addr_d = '0;
    wd_d   = '0;
    disp_d = 1'b0;
    deq    = 1'b0;
    if (slot) begin
      en_d   = 1'b1;
      addr_d = rd_addr;
      disp_d = 1'b1;
    end else if (st_q == CLEAR) begin
      en_d   = 1'b1;
      we_d   = 1'b1;
      addr_d = cnt_q;
      wd_d   = col_q;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        st_d   = IDLE;
        last_d = 1'b1;
      end
    end else if (!empty) begin
      en_d   = 1'b1;
      we_d   = 1'b1;
      addr_d = head.addr;
      wd_d   = head.data;
      deq    = 1'b1;
    end
    if (st_q == IDLE && clr_req) begin
      st_d  = CLEAR;
      cnt_d = '0;
      col_d = clr_color;
    end
  end

  // ready tracks next occupancy; rgb follows fetches
  always_comb begin
    lvl_n = lvl + LW'(enq) - LW'(deq);
    rdy_d = (lvl_n != LW'(QDEPTH));
    rgb_d = rdv_q ? bus.mem_rdata : rgb_q;
  end

  // all state and RAM port registers
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      col_q  <= '0;
      last_q <= 1'b0;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      disp_q <= 1'b0;
      rdv_q  <= 1'b0;
      rgb_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      col_q  <= col_d;
      last_q <= last_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
      en_q   <= en_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
      disp_q <= disp_d;
      rdv_q  <= disp_q;
      rgb_q  <= rgb_d;
    end
  end

  assign bus.cpu_wr_ready = rdy_q;
  assign bus.mem_en       = en_q;
  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wd_q;
  assign clr_busy         = (st_q == CLEAR) || last_q;
  assign rgb              = rgb_q;
  assign q_level          = lvl;
  assign addr_err         = err_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed bench for the
// framebuffer arbiter.
module tb_fb_arbiter;
  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic [9:0]  sx, sy;
  logic        de, clr_req;
  logic [2:0]  clr_color, rgb;
  logic [2:0]  ram_ret = 3'd0;
  logic        clr_busy, addr_err;
  logic [2:0]  q_level;
  int          checks = 0;
  int          failures = 0;

  fb_arbiter_if bus();

  fb_arbiter dut (
    .clk_pix   (clk_pix),
    .rst_pix   (rst_pix),
    .sx        (sx),
    .sy        (sy),
    .de        (de),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .rgb       (rgb),
    .q_level   (q_level),
    .addr_err  (addr_err),
    .bus       (bus)
  );

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) bus.mem_rdata <= 3'd0;
    else if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= ram_ret;
  end

  task automatic tick();
    @(posedge clk_pix);
    @(negedge clk_pix);
  endtask

  task automatic set_idle();
    sx = 10'd0;
    sy = 10'd0;
    de = 1'b0;
    clr_req = 1'b0;
    clr_color = 3'd0;
    bus.cpu_wr_valid = 1'b0;
    bus.cpu_wr_addr = 15'd0;
    bus.cpu_wr_data = 3'd0;
  endtask

  task automatic test_reset();
    logic [29:0] v;
    rst_pix = 1'b1;
    set_idle();
    repeat (2) @(posedge clk_pix);
    @(negedge clk_pix);
    v = {bus.mem_en, bus.mem_we, bus.mem_addr,
         bus.mem_wdata, rgb, q_level,
         bus.cpu_wr_ready, clr_busy, addr_err};
    checks++;
    if (v !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", v);
    end
    rst_pix = 1'b0;
    checks++;
    if (bus.cpu_wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_at_release got=%b exp=0",
               bus.cpu_wr_ready);
    end
    tick();
    checks++;
    if (bus.cpu_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_clk got=%b exp=1",
               bus.cpu_wr_ready);
    end
  endtask

  task automatic test_display_read();
    logic [9:0]  psx;
    logic        pde, ps;
    logic [14:0] ea;
    logic [2:0]  er;
    ram_ret = 3'd5;
    sy = 10'd8;
    pde = 1'b0;
    psx = 10'd0;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) begin
        ps = pde && (psx[1:0] == 2'b00);
        checks++;
        if ({bus.mem_en, bus.mem_we} !== {ps, 1'b0}) begin
          failures++;
          $display("FAIL rd_en sx=%0d got=%b%b exp=%b0",
                   psx, bus.mem_en, bus.mem_we, ps);
        end
        if (ps) begin
          ea = 15'd320 + 15'(psx[9:2]);
          checks++;
          if (bus.mem_addr !== ea) begin
            failures++;
            $display("FAIL rd_addr sx=%0d got=%0d exp=%0d",
                     psx, bus.mem_addr, ea);
          end
        end
        er = (i < 3) ? 3'd0 : (i < 7) ? 3'd5 : 3'd6;
        checks++;
        if (rgb !== er) begin
          failures++;
          $display("FAIL rgb step=%0d got=%0d exp=%0d",
                   i, rgb, er);
        end
      end
      if (i == 5) ram_ret = 3'd6;
      de = (i < 16);
      sx = 10'(i);
      pde = de;
      psx = sx;
      tick();
    end
    de = 1'b0;
  endtask

  task automatic test_addr_err();
    int bad;
    de = 1'b0;
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_addr = 15'd19199;
    bus.cpu_wr_data = 3'd3;
    tick();
    bus.cpu_wr_valid = 1'b0;
    checks++;
    if ({q_level, addr_err} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL edge_write_q got=%0d,%b exp=1,0",
               q_level, addr_err);
    end
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr,
         bus.mem_wdata} !== {2'b11, 15'd19199, 3'd3}) begin
      failures++;
      $display("FAIL edge_write_bus got=%b%b a=%0d d=%0d",
               bus.mem_en, bus.mem_we, bus.mem_addr,
               bus.mem_wdata);
    end
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_addr = 15'd19200;
    bus.cpu_wr_data = 3'd7;
    tick();
    bus.cpu_wr_valid = 1'b0;
    checks++;
    if ({addr_err, q_level} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL oob_write got=%b,%0d exp=1,0",
               addr_err, q_level);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.mem_en !== 1'b0 || addr_err !== 1'b1)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL oob_sticky bad=%0d exp=0", bad);
    end
  endtask

  task automatic test_clear();
    int bad, first;
    de = 1'b0;
    clr_color = 3'b010;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    checks++;
    if ({clr_busy, bus.mem_en} !== 2'b10) begin
      failures++;
      $display("FAIL clr_start got=%b%b exp=10",
               clr_busy, bus.mem_en);
    end
    bad = 0;
    first = -1;
    for (int k = 0; k < 19200; k++) begin
      tick();
      if (!(bus.mem_en === 1'b1 && bus.mem_we === 1'b1
            && bus.mem_addr === 15'(k)
            && bus.mem_wdata === 3'b010
            && clr_busy === 1'b1)) begin
        bad++;
        if (first < 0) first = k;
      end
      clr_req = (k == 100);
    end
    clr_req = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clr_seq bad=%0d first=%0d exp=0",
               bad, first);
    end
    tick();
    checks++;
    if ({clr_busy, bus.mem_en} !== 2'b00) begin
      failures++;
      $display("FAIL clr_end got=%b%b exp=00",
               clr_busy, bus.mem_en);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.mem_en !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clr_quiet bad=%0d exp=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] wa [4];
    logic [2:0]  wd [4];
    int c, bad, got, done;
    logic ps;
    wa = '{15'd10, 15'd20, 15'd30, 15'd40};
    wd = '{3'd1, 3'd2, 3'd3, 3'd4};
    c = 0;
    sy = 10'd8;
    de = 1'b0;
    clr_color = 3'b010;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus.cpu_wr_valid = 1'b1;
      bus.cpu_wr_addr = wa[j];
      bus.cpu_wr_data = wd[j];
      de = 1'b1;
      sx = 10'(c % 16);
      c++;
      tick();
      checks++;
      if ({bus.cpu_wr_ready, q_level}
          !== {(j < 3), 3'(j + 1)}) begin
        failures++;
        $display("FAIL b2b_push%0d got=%b,%0d exp=%b,%0d",
                 j, bus.cpu_wr_ready, q_level,
                 (j < 3), j + 1);
      end
    end
    bus.cpu_wr_addr = 15'd50;
    bus.cpu_wr_data = 3'd5;
    sx = 10'(c % 16);
    c++;
    tick();
    bus.cpu_wr_valid = 1'b0;
    checks++;
    if ({bus.cpu_wr_ready, q_level} !== {1'b0, 3'd4}) begin
      failures++;
      $display("FAIL b2b_full got=%b,%0d exp=0,4",
               bus.cpu_wr_ready, q_level);
    end
    bad = 0;
    done = 0;
    ps = 1'b0;
    for (int n = 0; n < 30000 && done == 0; n++) begin
      sx = 10'(c % 16);
      c++;
      ps = (sx[1:0] == 2'b00);
      tick();
      if (clr_busy === 1'b0) done = 1;
      else if (q_level !== 3'd4) bad++;
    end
    checks++;
    if (done !== 1) begin
      failures++;
      $display("FAIL b2b_clear_timeout got=%0d exp=1", done);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL b2b_hold_in_clear bad=%0d exp=0", bad);
    end
    bad = 0;
    got = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
        if (ps) bad++;
        if (got >= 4) bad++;
        else if ({bus.mem_addr, bus.mem_wdata}
                 !== {wa[got], wd[got]}) bad++;
        got++;
      end
      if (ps && !(bus.mem_en === 1'b1
                  && bus.mem_we === 1'b0)) bad++;
      sx = 10'(c % 16);
      c++;
      ps = (sx[1:0] == 2'b00);
      tick();
    end
    de = 1'b0;
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=4", got);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL b2b_order bad=%0d exp=0", bad);
    end
    checks++;
    if ({q_level, bus.cpu_wr_ready} !== {3'd0, 1'b1}) begin
      failures++;
      $display("FAIL b2b_drained got=%0d,%b exp=0,1",
               q_level, bus.cpu_wr_ready);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [29:0] v;
    int hit, bad;
    de = 1'b0;
    clr_color = 3'b010;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_addr = 15'd5;
    bus.cpu_wr_data = 3'd1;
    tick();
    bus.cpu_wr_addr = 15'd6;
    bus.cpu_wr_data = 3'd2;
    tick();
    bus.cpu_wr_valid = 1'b0;
    hit = 0;
    for (int n = 0; n < 400 && hit == 0; n++) begin
      if (bus.mem_we === 1'b1 && bus.mem_addr === 15'd100)
        hit = 1;
      else
        tick();
    end
    checks++;
    if ({hit[0], q_level} !== {1'b1, 3'd2}) begin
      failures++;
      $display("FAIL rst_setup got=%0d,%0d exp=1,2",
               hit, q_level);
    end
    rst_pix = 1'b1;
    #1;
    v = {bus.mem_en, bus.mem_we, bus.mem_addr,
         bus.mem_wdata, rgb, q_level,
         bus.cpu_wr_ready, clr_busy, addr_err};
    checks++;
    if (v !== 30'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h exp=0", v);
    end
    repeat (2) tick();
    rst_pix = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_en !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rst_no_access bad=%0d exp=0", bad);
    end
    checks++;
    if ({bus.cpu_wr_ready, q_level, clr_busy}
        !== {1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL rst_after got=%b,%0d,%b exp=1,0,0",
               bus.cpu_wr_ready, q_level, clr_busy);
    end
  endtask

  initial begin
    set_idle();
    rst_pix = 1'b1;
    test_reset();
    test_display_read();
    test_addr_err();
    test_clear();
    test_back_to_back();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
